// File: rtl/seg7_scan_mux.sv
`timescale 1ns / 1ps
// seg7_scan_mux: scan controller for a multiplexed common-anode 7-segment display.
// Holds a packed-BCD value and shows one digit per slot. New values are staged and
// copied into the displayed register only at frame boundaries, so a frame never tears.
// Each slot starts with a short all-off dead time so the anodes do not ghost.
module seg7_scan_mux #(
  parameter int unsigned NUM_DIGITS  = 8,
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLANK_CYC   = 16,
  parameter int unsigned CNT_W       = 17
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [4*NUM_DIGITS-1:0]   value,
  input  logic                      load,
  input  logic [NUM_DIGITS-1:0]     digit_en,
  input  logic                      lz_blank,
  output logic                      pending,
  output logic                      frame_tick,
  output logic [3:0]                bcd_out,
  output logic [NUM_DIGITS-1:0]     an
);

  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned VAL_W = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(NUM_DIGITS - 1);

  // Scan position
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  tick;
  logic                  boundary;

  // Value handshake
  logic [VAL_W-1:0]      staging_q, staging_d;
  logic [VAL_W-1:0]      shadow_q, shadow_d;
  logic                  pending_q, pending_d;
  logic                  frame_tick_q, frame_tick_d;

  // Digit selection and visibility
  logic [3:0]            nib;
  logic [NUM_DIGITS-1:0] upper_zero;
  logic                  leading_zero;
  logic                  visible;

  // Registered outputs
  logic [3:0]            bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  // Prescaler and digit index: one slot per REFRESH_DIV cycles, wrap after last digit.
  always_comb begin
    tick     = (cnt_q == CNT_MAX);
    boundary = tick && (idx_q == IDX_MAX);
    cnt_d    = cnt_q + CNT_W'(1);
    idx_d    = idx_q;
    if (tick) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Load handshake: stage on load, promote at the frame boundary. A load that lands
  // on the boundary itself bypasses staging so it is shown from the very next frame.
  always_comb begin
    staging_d    = staging_q;
    shadow_d     = shadow_q;
    pending_d    = pending_q;
    frame_tick_d = boundary;
    if (load) begin
      staging_d = value;
    end
    if (boundary) begin
      if (load) begin
        shadow_d = value;
      end else if (pending_q) begin
        shadow_d = staging_q;
      end
      pending_d = 1'b0;
    end else if (load) begin
      pending_d = 1'b1;
    end
  end

  // Leading-zero map: upper_zero[k] is set when digits k..top of the shown value are all 0.
  always_comb begin
    logic run;
    run        = 1'b1;
    upper_zero = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      run           = run && (shadow_q[4*k +: 4] == 4'h0);
      upper_zero[k] = run;
    end
  end

  // Visibility of the current digit: enabled, a decimal code, and not a suppressed zero.
  always_comb begin
    nib          = shadow_q[{idx_q, 2'b00} +: 4];
    leading_zero = lz_blank && (idx_q != '0) && upper_zero[idx_q];
    visible      = digit_en[idx_q] && (nib <= 4'd9) && !leading_zero;
  end

  // Output decode: nibble always follows the index; anode only after the dead time.
  always_comb begin
    bcd_d = nib;
    an_d  = '1;
    if ((cnt_q >= CNT_BLANK) && visible) begin
      an_d = ~(NUM_DIGITS'(1) << idx_q);
    end
  end

  // State and output registers, cleared immediately by the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      staging_q    <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      frame_tick_q <= 1'b0;
      bcd_q        <= 4'h0;
      an_q         <= '1;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      staging_q    <= staging_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      frame_tick_q <= frame_tick_d;
      bcd_q        <= bcd_d;
      an_q         <= an_d;
    end
  end

  assign pending    = pending_q;
  assign frame_tick = frame_tick_q;
  assign bcd_out    = bcd_q;
  assign an         = an_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
`timescale 1ns / 1ps
// Bench for seg7_scan_mux with a short refresh divider. A behavioural model tracks
// the scan position from a plain cycle count and checks every output each cycle.
module tb_seg7_scan_mux;

  localparam int ND  = 8;
  localparam int RD  = 8;
  localparam int BC  = 2;
  localparam int FRM = ND * RD;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] value;
  logic        load;
  logic [7:0]  digit_en;
  logic        lz_blank;
  logic        pending;
  logic        frame_tick;
  logic [3:0]  bcd_out;
  logic [7:0]  an;

  seg7_scan_mux #(
    .NUM_DIGITS (ND),
    .REFRESH_DIV(RD),
    .BLANK_CYC  (BC),
    .CNT_W      (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .value     (value),
    .load      (load),
    .digit_en  (digit_en),
    .lz_blank  (lz_blank),
    .pending   (pending),
    .frame_tick(frame_tick),
    .bcd_out   (bcd_out),
    .an        (an)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;

  // Model state: m_n is the number of clock edges since reset release.
  int          m_n;
  logic [31:0] m_stage, m_shadow;
  logic        m_pend;
  logic [7:0]  e_an;
  logic [3:0]  e_bcd;
  logic        e_pend, e_ft;

  typedef struct {
    logic [31:0] val;
    logic [7:0]  en;
    logic        lz;
    logic [7:0]  lit;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (model cycle %0d)", name, act, exp, m_n);
    end
  endtask

  function automatic bit ref_visible(input logic [31:0] sh, input int k, input logic [7:0] en,
                                     input logic lz);
    logic [31:0] upper;
    upper = sh >> (4 * k);
    if (!en[k]) return 1'b0;
    if ((upper & 32'hF) > 9) return 1'b0;
    if (lz && k != 0 && upper == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] count_word(input logic [7:0] lit);
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < ND; k++) if (lit[k]) w[4*k +: 4] = 4'(RD - BC);
    return w;
  endfunction

  // One clock: update the model from the inputs seen at the edge, then check on negedge.
  task automatic cycle();
    int  c, k;
    bit  bnd;
    @(posedge clk);
    c     = m_n % RD;
    k     = (m_n / RD) % ND;
    bnd   = (c == RD - 1) && (k == ND - 1);
    e_bcd = 4'((m_shadow >> (4 * k)) & 32'hF);
    e_an  = (c < BC || !ref_visible(m_shadow, k, digit_en, lz_blank)) ? 8'hFF : ~(8'(1) << k);
    e_ft  = bnd;
    if (load && bnd) begin
      m_shadow = value;
      m_stage  = value;
      m_pend   = 1'b0;
    end else begin
      if (bnd && m_pend) begin
        m_shadow = m_stage;
        m_pend   = 1'b0;
      end
      if (load) begin
        m_stage = value;
        m_pend  = 1'b1;
      end
    end
    e_pend = m_pend;
    m_n++;
    @(negedge clk);
    chk("an", an, e_an);
    chk("bcd_out", bcd_out, e_bcd);
    chk("pending", pending, e_pend);
    chk("frame_tick", frame_tick, e_ft);
    chk("an_onehot0", $onehot0(~an), 1);
  endtask

  // Called at a negedge: assert reset between edges and check it acts without a clock.
  task automatic reset_pulse(input string tag);
    #2 rst = 1'b1;
    #1;
    chk({tag, "_an"}, an, 8'hFF);
    chk({tag, "_bcd"}, bcd_out, 4'h0);
    chk({tag, "_pending"}, pending, 1'b0);
    chk({tag, "_frame_tick"}, frame_tick, 1'b0);
    #1 rst = 1'b0;
    m_n      = 0;
    m_stage  = '0;
    m_shadow = '0;
    m_pend   = 1'b0;
  endtask

  task automatic wait_tick();
    bit found = 1'b0;
    for (int i = 0; i < 2 * FRM + 10 && !found; i++) begin
      if (frame_tick === 1'b1) found = 1'b1;
      else cycle();
    end
    chk("frame_tick_seen", found, 1'b1);
  endtask

  // From a frame_tick sample, watch one full frame: lit cycles and nibble per digit.
  task automatic observe_frame(output logic [31:0] counts, output logic [31:0] bcds);
    int lit_n[ND];
    for (int k = 0; k < ND; k++) lit_n[k] = 0;
    bcds = '0;
    for (int j = 0; j < FRM; j++) begin
      int slot;
      cycle();
      slot = j / RD;
      if (an == ~(8'(1) << slot)) lit_n[slot]++;
      if (j % RD == RD - 1) bcds[4*slot +: 4] = bcd_out;
    end
    counts = '0;
    for (int k = 0; k < ND; k++) counts[4*k +: 4] = 4'(lit_n[k]);
  endtask

  task automatic load_value(input logic [31:0] v);
    value = v;
    load  = 1'b1;
    cycle();
    load  = 1'b0;
    value = $urandom;
  endtask

  initial begin
    vec_t        vecs[10];
    logic [31:0] counts, bcds;
    int          ticks[$];
    int          t;
    bit          seen;

    vecs[0] = '{32'h8765_4321, 8'hFF, 1'b0, 8'hFF};
    vecs[1] = '{32'h0000_0105, 8'hFF, 1'b1, 8'h07};
    vecs[2] = '{32'h0000_0000, 8'hFF, 1'b1, 8'h01};
    vecs[3] = '{32'h0000_00A3, 8'hFF, 1'b0, 8'hFD};
    vecs[4] = '{32'h0000_00A3, 8'hFD, 1'b0, 8'hFD};
    vecs[5] = '{32'h0000_00A3, 8'hFF, 1'b1, 8'h01};
    vecs[6] = '{32'hF000_0000, 8'hFF, 1'b1, 8'h7F};
    vecs[7] = '{32'h1000_0000, 8'hFF, 1'b1, 8'hFF};
    vecs[8] = '{32'h0000_0105, 8'h5A, 1'b0, 8'h5A};
    vecs[9] = '{32'h0909_0000, 8'hFF, 1'b1, 8'h7F};

    rst      = 1'b1;
    value    = '0;
    load     = 1'b0;
    digit_en = 8'hFF;
    lz_blank = 1'b0;
    m_n      = 0;
    repeat (2) @(negedge clk);
    reset_pulse("por");
    repeat (10) cycle();

    // Table: load, wait for the frame that shows it, check lit time and nibbles.
    for (int i = 0; i < 10; i++) begin
      digit_en = vecs[i].en;
      lz_blank = vecs[i].lz;
      load_value(vecs[i].val);
      wait_tick();
      observe_frame(counts, bcds);
      chk($sformatf("vec%0d_lit", i), counts, count_word(vecs[i].lit));
      chk($sformatf("vec%0d_bcd", i), bcds, vecs[i].val);
    end
    digit_en = 8'hFF;
    lz_blank = 1'b0;

    // Two loads in one frame: the last one wins.
    wait_tick();
    repeat (3) cycle();
    load_value(32'h1111_1111);
    chk("two_load_pending", pending, 1'b1);
    repeat (5) cycle();
    load_value(32'h2222_2222);
    wait_tick();
    observe_frame(counts, bcds);
    chk("two_load_bcd", bcds, 32'h2222_2222);

    // Load exactly on the boundary edge: shown next frame, pending never rises.
    for (int i = 0; i < FRM + 2 && (m_n % FRM) != FRM - 1; i++) cycle();
    chk("coinc_aligned", m_n % FRM, FRM - 1);
    load_value(32'h3333_3333);
    chk("coinc_tick", frame_tick, 1'b1);
    chk("coinc_pending", pending, 1'b0);
    seen = 1'b0;
    for (int j = 0; j < FRM; j++) begin
      cycle();
      if (pending) seen = 1'b1;
      if (j == FRM - 1) chk("coinc_bcd7", bcd_out, 4'h3);
    end
    chk("coinc_never_pending", seen, 1'b0);

    // Reset in the middle of a slot while digit 0 is lit.
    for (int i = 0; i < FRM + 2 && an !== 8'hFE; i++) cycle();
    chk("midscan_pre_an", an, 8'hFE);
    reset_pulse("midscan");

    // Free-run: frame_tick every FRM cycles, index wraps from the last digit to 0.
    t = 0;
    for (int i = 0; i < 3 * FRM + 20; i++) begin
      cycle();
      t++;
      if (frame_tick) begin
        ticks.push_back(t);
        chk("wrap_an_last", an, 8'h7F);
      end
    end
    chk("tick_count", ticks.size(), 3);
    if (ticks.size() >= 3) begin
      chk("tick_first", ticks[0], FRM);
      chk("tick_period1", ticks[1] - ticks[0], FRM);
      chk("tick_period2", ticks[2] - ticks[1], FRM);
    end

    // Random traffic against the model, including live enable and blanking changes.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] v;
      v = '0;
      for (int k = 0; k < ND; k++)
        if ($urandom_range(1, 0) == 1) v[4*k +: 4] = 4'($urandom_range(15, 0));
      value = v;
      load  = ($urandom_range(15, 0) == 0);
      if ($urandom_range(31, 0) == 0) digit_en = 8'($urandom);
      if ($urandom_range(31, 0) == 0) lz_blank = 1'($urandom);
      cycle();
    end
    load = 1'b0;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
